// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 key sequencer: scan-code prefix/status bytes
// and the sequencer state encoding.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_HOLD    = 3'd4
    } ps2_state_e;

    localparam logic [7:0] BYTE_EXT    = 8'hE0;
    localparam logic [7:0] BYTE_BRK    = 8'hF0;
    localparam logic [7:0] BYTE_BAT    = 8'hAA;
    localparam logic [7:0] BYTE_ACK    = 8'hFA;
    localparam logic [7:0] BYTE_ECHO   = 8'hEE;
    localparam logic [7:0] BYTE_ERR_00 = 8'h00;
    localparam logic [7:0] BYTE_ERR_FC = 8'hFC;
    localparam logic [7:0] BYTE_ERR_FF = 8'hFF;

    // Keyboard-reported error / overrun codes.
    function automatic logic is_err_byte(input logic [7:0] b);
        return (b == BYTE_ERR_00) || (b == BYTE_ERR_FC) || (b == BYTE_ERR_FF);
    endfunction

endpackage

// File: rtl/ps2_timeout_cnt.sv
// Prefix timeout counter: counts idle cycles while a prefix byte is waiting
// for its follower; flags the last allowed cycle.
module ps2_timeout_cnt
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 200000,
    parameter int unsigned TW          = 18
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TW-1:0] LAST_CNT = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Clear takes priority so every received byte restarts the window.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    assign expired = en && (cnt_q == LAST_CNT);

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ps2_key_sequencer.sv
// Assembles PS/2 scan-code bytes into key events (code + extended + break),
// with a valid/ready hand-off, BAT-ok flag and error pulse.
//
// state      | meaning
// -----------+------------------------------------------
// ST_IDLE    | waiting for first byte of a sequence
// ST_EXT     | E0 seen, waiting for F0 or code
// ST_BRK     | F0 seen, waiting for code
// ST_EXT_BRK | E0 F0 seen, waiting for code
// ST_HOLD    | event pending, receiver disabled
module ps2_key_sequencer
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 200000,
    parameter int unsigned TW          = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    output logic       rx_en,
    output logic       key_valid,
    input  logic       key_ready,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       bat_ok,
    output logic       err_tick
);

    ps2_state_e state_q, state_d;
    logic [7:0] key_code_q, key_code_d;
    logic       key_ext_q, key_ext_d;
    logic       key_break_q, key_break_d;
    logic       key_valid_q, key_valid_d;
    logic       rx_en_q, rx_en_d;
    logic       bat_ok_q, bat_ok_d;
    logic       err_tick_q, err_tick_d;

    logic in_prefix;
    logic expired;

    assign in_prefix = (state_q == ST_EXT) || (state_q == ST_BRK) || (state_q == ST_EXT_BRK);

    ps2_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TW          (TW)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clr     (rx_done_tick || !in_prefix),
        .en      (in_prefix),
        .expired (expired)
    );

    // Next-state and output decode; a byte arriving on the timeout cycle wins.
    always_comb begin
        state_d     = state_q;
        key_code_d  = key_code_q;
        key_ext_d   = key_ext_q;
        key_break_d = key_break_q;
        bat_ok_d    = bat_ok_q;
        err_tick_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rx_done_tick) begin
                    if (rx_data == BYTE_EXT) begin
                        state_d = ST_EXT;
                    end else if (rx_data == BYTE_BRK) begin
                        state_d = ST_BRK;
                    end else if (rx_data == BYTE_BAT) begin
                        bat_ok_d = 1'b1;
                    end else if ((rx_data == BYTE_ACK) || (rx_data == BYTE_ECHO)) begin
                        state_d = ST_IDLE;
                    end else if (is_err_byte(rx_data)) begin
                        err_tick_d = 1'b1;
                    end else begin
                        key_code_d  = rx_data;
                        key_ext_d   = 1'b0;
                        key_break_d = 1'b0;
                        state_d     = ST_HOLD;
                    end
                end
            end
            ST_EXT, ST_BRK, ST_EXT_BRK: begin
                if (rx_done_tick) begin
                    if (is_err_byte(rx_data)) begin
                        err_tick_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else if ((state_q == ST_EXT) && (rx_data == BYTE_BRK)) begin
                        state_d = ST_EXT_BRK;
                    end else if ((state_q == ST_EXT) && (rx_data == BYTE_EXT)) begin
                        state_d = ST_EXT;
                    end else begin
                        key_code_d  = rx_data;
                        key_ext_d   = (state_q != ST_BRK);
                        key_break_d = (state_q != ST_EXT);
                        state_d     = ST_HOLD;
                    end
                end else if (expired) begin
                    err_tick_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (key_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        key_valid_d = (state_d == ST_HOLD);
        rx_en_d     = (state_d != ST_HOLD);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            key_code_q  <= 8'h00;
            key_ext_q   <= 1'b0;
            key_break_q <= 1'b0;
            key_valid_q <= 1'b0;
            rx_en_q     <= 1'b0;
            bat_ok_q    <= 1'b0;
            err_tick_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_code_q  <= key_code_d;
            key_ext_q   <= key_ext_d;
            key_break_q <= key_break_d;
            key_valid_q <= key_valid_d;
            rx_en_q     <= rx_en_d;
            bat_ok_q    <= bat_ok_d;
            err_tick_q  <= err_tick_d;
        end
    end

    assign rx_en     = rx_en_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_ext   = key_ext_q;
    assign key_break = key_break_q;
    assign bat_ok    = bat_ok_q;
    assign err_tick  = err_tick_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed bench for ps2_key_sequencer with a short prefix timeout.
module tb_ps2_key_sequencer;

    logic       clk;
    logic       reset;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       rx_en;
    logic       key_valid;
    logic       key_ready;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       bat_ok;
    logic       err_tick;

    int total = 0;
    int bad   = 0;

    ps2_key_sequencer #(
        .TIMEOUT_CYC (100),
        .TW          (18)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .rx_en        (rx_en),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .key_code     (key_code),
        .key_ext      (key_ext),
        .key_break    (key_break),
        .bat_ok       (bat_ok),
        .err_tick     (err_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the byte is sampled by the next posedge and the
    // task returns at the following negedge.
    task automatic send(input logic [7:0] b);
        rx_done_tick = 1'b1;
        rx_data      = b;
        @(negedge clk);
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;
    endtask

    task automatic check_event(input string tag, input logic [7:0] code,
                               input logic ext, input logic brk);
        check({tag, "_valid"}, key_valid, 1);
        check({tag, "_code"}, key_code, code);
        check({tag, "_ext"}, key_ext, ext);
        check({tag, "_brk"}, key_break, brk);
        check({tag, "_rx_en"}, rx_en, 0);
    endtask

    int err_cnt;
    int err_idx;
    int valid_seen;

    initial begin
        reset        = 1'b0;
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;
        key_ready    = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_rx_en", rx_en, 0);
        check("rst_valid", key_valid, 0);
        check("rst_code", key_code, 8'h00);
        check("rst_bat", bat_ok, 0);
        check("rst_err", err_tick, 0);

        reset = 1'b1;
        @(negedge clk);
        check("post_rst_rx_en", rx_en, 1);

        // Plain make code, accepted immediately.
        send(8'h1C);
        check_event("make", 8'h1C, 0, 0);
        @(negedge clk);
        check("make_done_valid", key_valid, 0);
        check("make_done_rx_en", rx_en, 1);

        // Break code.
        send(8'hF0);
        check("brk_prefix_valid", key_valid, 0);
        send(8'h1C);
        check_event("brk", 8'h1C, 0, 1);
        @(negedge clk);

        // Extended break.
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        check_event("extbrk", 8'h75, 1, 1);
        @(negedge clk);

        // Extended make, with a repeated E0.
        send(8'hE0);
        send(8'hE0);
        send(8'h6B);
        check_event("extmake", 8'h6B, 1, 0);
        @(negedge clk);

        // Prefix timeout: E0 then silence.
        send(8'hE0);
        check("to_start_err", err_tick, 0);
        err_cnt    = 0;
        err_idx    = -1;
        valid_seen = 0;
        for (int i = 0; i < 110; i++) begin
            @(negedge clk);
            if (err_tick) begin
                err_cnt++;
                err_idx = i;
            end
            if (key_valid) valid_seen++;
        end
        check("to_err_count", err_cnt, 1);
        check("to_err_cycle", err_idx, 99);
        check("to_no_valid", valid_seen, 0);
        send(8'h1C);
        check_event("after_to", 8'h1C, 0, 0);
        @(negedge clk);

        // Backpressure: byte in HOLD is dropped.
        key_ready = 1'b0;
        send(8'h1C);
        check_event("hold", 8'h1C, 0, 0);
        send(8'h32);
        check("hold_drop_code", key_code, 8'h1C);
        check("hold_drop_valid", key_valid, 1);
        repeat (3) @(negedge clk);
        check("hold_stable_code", key_code, 8'h1C);
        key_ready = 1'b1;
        @(negedge clk);
        check("hold_release_valid", key_valid, 0);
        @(negedge clk);
        check("hold_no_ghost", key_valid, 0);

        // Discarded status bytes.
        send(8'hFA);
        check("ack_discard", key_valid, 0);
        send(8'hEE);
        check("echo_discard", key_valid, 0);

        // Error byte inside a prefix.
        send(8'hE0);
        send(8'h00);
        check("pfx_err_tick", err_tick, 1);
        check("pfx_err_valid", key_valid, 0);
        @(negedge clk);
        check("pfx_err_pulse", err_tick, 0);

        // BAT and error byte.
        send(8'hAA);
        check("bat_set", bat_ok, 1);
        check("bat_no_valid", key_valid, 0);
        send(8'hFF);
        check("ff_err", err_tick, 1);
        check("bat_sticky", bat_ok, 1);
        @(negedge clk);
        check("ff_err_pulse", err_tick, 0);

        // Reset in the middle of a break prefix.
        send(8'hF0);
        reset = 1'b0;
        #1;
        check("mid_rst_rx_en", rx_en, 0);
        check("mid_rst_valid", key_valid, 0);
        check("mid_rst_code", key_code, 8'h00);
        check("mid_rst_ext", key_ext, 0);
        check("mid_rst_brk", key_break, 0);
        check("mid_rst_bat", bat_ok, 0);
        check("mid_rst_err", err_tick, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_rel_rx_en", rx_en, 1);
        send(8'h1C);
        check_event("after_mid_rst", 8'h1C, 0, 0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
